game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
// - Central game sequencer: owns MENU/PLAYING/DEAD/WIN state, player row, score, lives, level.
// - Drives the UI text renderer (state, score, blink) and raises sound-event requests via a
//   valid/ready handshake.
// - Sits between the button debouncers/collision logic and the renderers; clocked by the pixel clock.
// PARAMETERS
// - ROWS          13   lane rows; the player row runs 0..ROWS-1, and ROWS-1 is the goal row
// - LIVES         3    lives granted at game start (<=3, fits 2 bits)
// - DEAD_FRAMES   90   frames held in DEAD before leaving it
// - WIN_FRAMES    120  frames held in WIN before next level
// - BLINK_FRAMES  30   frames per half-period of the subtitle blink
// - GOAL_BONUS    50   score added on reaching the goal
// - SCORE_MAX     999  score saturation value (3 displayed digits)
// PORTS
// - clk            in   1   pixel clock
// - rst_n          in   1   synchronous reset, active low
// - frame_tick     in   1   one-cycle pulse per video frame
// - btn_up_tick    in   1   one-cycle debounced press
// - btn_down_tick  in   1   one-cycle debounced press
// - btn_any_tick   in   1   OR of all button ticks
// - collision      in   1   level-sensitive hit from the sprite logic
// - state          out  2   0=MENU 1=PLAYING 2=DEAD 3=WIN
// - curr_row       out  4   player row
// - score          out  10  best-row score plus bonuses, saturating
// - lives          out  2   remaining lives
// - level          out  4   current level, wraps 15->0
// - blink          out  1   subtitle visible flag
// - sound_valid    out  1   sound request pending
// - sound_type     out  2   0=UI_PRESS 1=NEXTLEVEL 2=CRASH 3=CELEBRATION
// - sound_ready    in   1   sound engine accepts the request
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - state=MENU, curr_row=0, score=0, best=0, lives=LIVES, level=0, blink=1
//   - sound_valid=0, sound_type=0, all counters 0
// - All outputs are registered and change the clock after the causing input.
// - MENU:
//   - blink toggles every BLINK_FRAMES frame_ticks.
//   - btn_any_tick -> PLAYING; clears curr_row, score, best; lives=LIVES, level=0; posts UI_PRESS.
//   - score keeps the last game's value until that start.
// - PLAYING, priority per cycle: collision > goal > movement.
//   - collision=1 -> DEAD; lives-=1 (stays 0 if already 0); posts CRASH.
//   - btn_up_tick with curr_row==ROWS-2 -> WIN; curr_row=ROWS-1; posts CELEBRATION.
//     Score becomes min(score+1+GOAL_BONUS, SCORE_MAX).
//   - btn_up_tick otherwise -> curr_row+=1. If the new row exceeds best, best:=new row and
//     score+=1 (saturating).
//   - btn_down_tick -> curr_row-=1, saturating at 0; score unchanged.
//   - up and down in the same cycle -> no movement.
// - DEAD:
//   - Buttons and collision are ignored.
//   - After DEAD_FRAMES frame_ticks: lives==0 -> MENU with blink=1; else PLAYING with
//     curr_row=0 and best=0.
// - WIN:
//   - Buttons and collision are ignored.
//   - After WIN_FRAMES frame_ticks -> PLAYING; curr_row=0, best=0, level+=1; posts NEXTLEVEL.
// - Hold counter:
//   - Loads 0 on entry to DEAD/WIN.
//   - Counts frame_ticks only; exits on the tick that makes the count equal the limit.
//   - A frame_tick on the entry cycle is not counted.
// - Sound handshake:
//   - Single-entry register. Posting sets sound_valid=1 and loads sound_type.
//   - Cleared on a cycle where valid && ready, unless a new post arrives that same cycle.
//   - A new post while one is pending overwrites sound_type (newest wins).
//   - sound_type is stable while valid && !ready, except on such an overwrite.
// - Reset mid-hold or mid-handshake returns every output to its reset value next cycle.
// STRUCTURE
// - frogger_pkg:
//   - enums state_t {MENU,PLAYING,DEAD,WIN} and sound_t {UI_PRESS,NEXTLEVEL,CRASH,CELEBRATION}
//   - SCORE_MAX
// - Sub-module frame_down_counter: loadable frame-tick counter with a done pulse.
//   - One instance for the DEAD/WIN hold, one for blink.
// - Top level: one state FSM, the row/score datapath, the sound request register.
// TESTING
// - Reset, then btn_any_tick
//   -> state=1, lives=3, score=0, sound_valid=1, type=0.
//   - Hold sound_ready=0 for 5 cycles -> valid and type held; ready=1 -> valid=0 next cycle.
// - From row 0: 3 up ticks, 2 down, 2 up
//   -> curr_row=3, score=3.
//   - Up and down ticks in the same cycle -> curr_row unchanged.
// - PLAYING at row 11: btn_up_tick with collision=1 the same cycle
//   -> DEAD, lives=2, sound_type=2, row stays 11.
// - Lives=1: collision, then 90 frame_ticks
//   -> state=MENU; score retained; blink=1, toggling every 30 frames.
// - Reach row 12
//   -> WIN, type=3, score=12+50=62.
//   - After 120 frames -> PLAYING, level=1, curr_row=0, type=1.
// - Score at 990, goal
//   -> score=999.
//   - Assert rst_n=0 during WIN -> all outputs return to reset values.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and helpers for the game sequencer: state and sound encodings,
// score ceiling and a saturating score adder.
package frogger_pkg;

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        PLAYING = 2'd1,
        DEAD    = 2'd2,
        WIN     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        UI_PRESS    = 2'd0,
        NEXTLEVEL   = 2'd1,
        CRASH       = 2'd2,
        CELEBRATION = 2'd3
    } sound_t;

    localparam int unsigned SCORE_MAX = 999;
    localparam int unsigned SCORE_W   = 10;

    // One extra bit of headroom so a large bonus cannot wrap before the clamp.
    function automatic logic [SCORE_W-1:0] score_add(
        input logic [SCORE_W-1:0] base,
        input logic [6:0]         inc,
        input logic [SCORE_W-1:0] ceiling
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, base} + {4'b0000, inc};
        return (sum > {1'b0, ceiling}) ? ceiling : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Frame-tick counter: clear zeroes it, each enabled tick advances it, and done
// pulses on the tick that reaches the limit (the count then restarts at zero).
module frame_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count_q;

    assign done = en && tick && (count_q == limit - W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en && tick) begin
            count_q <= done ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Central game sequencer: MENU/PLAYING/DEAD/WIN FSM, row/score/lives/level
// datapath, subtitle blink and a single-entry sound request register.
module game_state_ctrl
    import frogger_pkg::*;
#(
    parameter int unsigned ROWS         = 13,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned DEAD_FRAMES  = 90,
    parameter int unsigned WIN_FRAMES   = 120,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned GOAL_BONUS   = 50,
    parameter int unsigned SCORE_MAX    = frogger_pkg::SCORE_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up_tick,
    input  logic       btn_down_tick,
    input  logic       btn_any_tick,
    input  logic       collision,
    output logic [1:0] state,
    output logic [3:0] curr_row,
    output logic [9:0] score,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic       blink,
    output logic       sound_valid,
    output logic [1:0] sound_type,
    input  logic       sound_ready
);

    localparam logic [1:0] ST_MENU    = MENU;
    localparam logic [1:0] ST_PLAYING = PLAYING;
    localparam logic [1:0] ST_DEAD    = DEAD;
    localparam logic [1:0] ST_WIN     = WIN;

    localparam int unsigned HOLD_MAX = (DEAD_FRAMES > WIN_FRAMES) ? DEAD_FRAMES : WIN_FRAMES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int unsigned BLINK_W  = $clog2(BLINK_FRAMES + 1);

    localparam logic [3:0]         GOAL_ROW   = 4'(ROWS - 1);
    localparam logic [3:0]         LAST_STEP  = 4'(ROWS - 2);
    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
    localparam logic [6:0]         GOAL_INC   = 7'(GOAL_BONUS + 1);
    localparam logic [SCORE_W-1:0] SCORE_CEIL = SCORE_W'(SCORE_MAX);

    logic [1:0]         state_q, state_d;
    logic [3:0]         row_q, row_d, row_up;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         best_q, best_d;
    logic [1:0]         lives_q, lives_d;
    logic [3:0]         level_q, level_d;
    logic               blink_q, blink_d;
    logic               snd_valid_q;
    logic [1:0]         snd_type_q;

    logic               post;
    logic [1:0]         post_type;
    logic               move_up, move_down;

    logic               hold_clear, hold_en, hold_done;
    logic [HOLD_W-1:0]  hold_limit;
    logic               blink_clear, blink_en, blink_done;

    assign move_up   = btn_up_tick && !btn_down_tick;
    assign move_down = btn_down_tick && !btn_up_tick;
    assign row_up    = row_q + 4'd1;

    // The hold count restarts whenever PLAYING is left (always into DEAD or WIN).
    assign hold_en    = (state_q == ST_DEAD) || (state_q == ST_WIN);
    assign hold_clear = (state_q == ST_PLAYING) && (state_d != ST_PLAYING);
    assign hold_limit = (state_q == ST_DEAD) ? HOLD_W'(DEAD_FRAMES) : HOLD_W'(WIN_FRAMES);

    assign blink_en    = (state_q == ST_MENU);
    assign blink_clear = (state_q != ST_MENU) && (state_d == ST_MENU);

    frame_down_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (hold_clear),
        .en    (hold_en),
        .tick  (frame_tick),
        .limit (hold_limit),
        .done  (hold_done)
    );

    frame_down_counter #(.W(BLINK_W)) u_blink_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (blink_clear),
        .en    (blink_en),
        .tick  (frame_tick),
        .limit (BLINK_W'(BLINK_FRAMES)),
        .done  (blink_done)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        score_d   = score_q;
        best_d    = best_q;
        lives_d   = lives_q;
        level_d   = level_q;
        blink_d   = blink_q;
        post      = 1'b0;
        post_type = UI_PRESS;

        case (state_q)
            ST_MENU: begin
                if (btn_any_tick) begin
                    state_d   = ST_PLAYING;
                    row_d     = 4'd0;
                    score_d   = '0;
                    best_d    = 4'd0;
                    lives_d   = LIVES_INIT;
                    level_d   = 4'd0;
                    post      = 1'b1;
                    post_type = UI_PRESS;
                end else if (blink_done) begin
                    blink_d = !blink_q;
                end
            end
            // Priority inside PLAYING: collision, then goal, then plain movement.
            ST_PLAYING: begin
                if (collision) begin
                    state_d   = ST_DEAD;
                    lives_d   = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    post      = 1'b1;
                    post_type = CRASH;
                end else if (move_up && (row_q == LAST_STEP)) begin
                    state_d   = ST_WIN;
                    row_d     = GOAL_ROW;
                    score_d   = score_add(score_q, GOAL_INC, SCORE_CEIL);
                    post      = 1'b1;
                    post_type = CELEBRATION;
                end else if (move_up) begin
                    row_d = row_up;
                    if (row_up > best_q) begin
                        best_d  = row_up;
                        score_d = score_add(score_q, 7'd1, SCORE_CEIL);
                    end
                end else if (move_down && (row_q != 4'd0)) begin
                    row_d = row_q - 4'd1;
                end
            end
            ST_DEAD: begin
                if (hold_done) begin
                    if (lives_q == 2'd0) begin
                        state_d = ST_MENU;
                        blink_d = 1'b1;
                    end else begin
                        state_d = ST_PLAYING;
                        row_d   = 4'd0;
                        best_d  = 4'd0;
                    end
                end
            end
            ST_WIN: begin
                if (hold_done) begin
                    state_d   = ST_PLAYING;
                    row_d     = 4'd0;
                    best_d    = 4'd0;
                    level_d   = level_q + 4'd1;
                    post      = 1'b1;
                    post_type = NEXTLEVEL;
                end
            end
            default: state_d = ST_MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_MENU;
            row_q   <= 4'd0;
            score_q <= '0;
            best_q  <= 4'd0;
            lives_q <= LIVES_INIT;
            level_q <= 4'd0;
            blink_q <= 1'b1;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            score_q <= score_d;
            best_q  <= best_d;
            lives_q <= lives_d;
            level_q <= level_d;
            blink_q <= blink_d;
        end
    end

    // Handshake: a request is offered while sound_valid=1 and consumed on any
    // cycle with sound_valid && sound_ready; sound_type holds until consumed,
    // except that a fresh post always replaces it (newest wins).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snd_valid_q <= 1'b0;
            snd_type_q  <= 2'd0;
        end else if (post) begin
            snd_valid_q <= 1'b1;
            snd_type_q  <= post_type;
        end else if (snd_valid_q && sound_ready) begin
            snd_valid_q <= 1'b0;
        end
    end

    assign state       = state_q;
    assign curr_row    = row_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign blink       = blink_q;
    assign sound_valid = snd_valid_q;
    assign sound_type  = snd_type_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomized bench for game_state_ctrl: a rule-level game model feeds an
// expected-output queue and a sound-event queue that two monitors drain.
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, frame_tick, btn_up_tick, btn_down_tick, btn_any_tick, collision;
    logic       sound_ready;
    logic [1:0] state, lives, sound_type;
    logic [3:0] curr_row, level;
    logic [9:0] score;
    logic       blink, sound_valid;

    always #5 clk = ~clk;

    game_state_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .btn_up_tick   (btn_up_tick),
        .btn_down_tick (btn_down_tick),
        .btn_any_tick  (btn_any_tick),
        .collision     (collision),
        .state         (state),
        .curr_row      (curr_row),
        .score         (score),
        .lives         (lives),
        .level         (level),
        .blink         (blink),
        .sound_valid   (sound_valid),
        .sound_type    (sound_type),
        .sound_ready   (sound_ready)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [25:0] exp_q[$];
    logic [1:0]  snd_q[$];

    // Game model state kept as plain integers.
    int m_state, m_row, m_score, m_best, m_lives, m_level;
    int m_blink, m_bcnt, m_hold, m_v, m_t;

    function automatic logic [25:0] pack_model();
        return {2'(m_state), 4'(m_row), 10'(m_score), 2'(m_lives), 4'(m_level),
                1'(m_blink), 1'(m_v), 2'(m_t)};
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit r, input bit up, input bit dn, input bit anyb,
                              input bit col, input bit ft, input bit rdy);
        bit post;
        int ptype;
        bit mu, md;
        if (!r) begin
            m_state = 0; m_row = 0; m_score = 0; m_best = 0; m_lives = 3; m_level = 0;
            m_blink = 1; m_bcnt = 0; m_hold = 0; m_v = 0; m_t = 0;
            snd_q.delete();
            return;
        end
        post = 0; ptype = 0;
        mu = up && !dn;
        md = dn && !up;
        case (m_state)
            0: begin
                if (anyb) begin
                    m_state = 1; m_row = 0; m_score = 0; m_best = 0; m_lives = 3; m_level = 0;
                    post = 1; ptype = 0;
                end else if (ft) begin
                    m_bcnt++;
                    if (m_bcnt == 30) begin
                        m_bcnt = 0;
                        m_blink = 1 - m_blink;
                    end
                end
            end
            1: begin
                if (col) begin
                    m_state = 2; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_hold = 0;
                    post = 1; ptype = 2;
                end else if (mu && m_row == 11) begin
                    m_state = 3; m_row = 12; m_score = min_int(m_score + 51, 999); m_hold = 0;
                    post = 1; ptype = 3;
                end else if (mu) begin
                    m_row++;
                    if (m_row > m_best) begin
                        m_best = m_row;
                        m_score = min_int(m_score + 1, 999);
                    end
                end else if (md && m_row > 0) begin
                    m_row--;
                end
            end
            2: begin
                if (ft) begin
                    m_hold++;
                    if (m_hold == 90) begin
                        if (m_lives == 0) begin
                            m_state = 0; m_blink = 1; m_bcnt = 0;
                        end else begin
                            m_state = 1; m_row = 0; m_best = 0;
                        end
                    end
                end
            end
            default: begin
                if (ft) begin
                    m_hold++;
                    if (m_hold == 120) begin
                        m_state = 1; m_row = 0; m_best = 0; m_level = (m_level + 1) % 16;
                        post = 1; ptype = 1;
                    end
                end
            end
        endcase
        if (post) begin
            if (m_v == 1 && !rdy) void'(snd_q.pop_back());
            snd_q.push_back(2'(ptype));
            m_v = 1;
            m_t = ptype;
        end else if (m_v == 1 && rdy) begin
            m_v = 0;
        end
    endtask

    task automatic drive(input bit r, input bit up, input bit dn, input bit anyb,
                         input bit col, input bit ft, input bit rdy);
        @(negedge clk);
        rst_n = r; btn_up_tick = up; btn_down_tick = dn; btn_any_tick = anyb;
        collision = col; frame_tick = ft; sound_ready = rdy;
        model_step(r, up, dn, anyb, col, ft, rdy);
        exp_q.push_back(pack_model());
    endtask

    task automatic rand_cycle(input int p_up, input int p_dn, input int p_col,
                              input int p_ft, input int p_rdy);
        bit up, dn, other;
        up    = ($urandom_range(99) < p_up);
        dn    = ($urandom_range(99) < p_dn);
        other = ($urandom_range(99) < 5);
        drive(1, up, dn, up | dn | other, ($urandom_range(99) < p_col),
              ($urandom_range(99) < p_ft), ($urandom_range(99) < p_rdy));
    endtask

    task automatic run_until(input int st, input int p_up, input int p_ft, input int budget);
        int n;
        n = 0;
        while (m_state != st && n < budget) begin
            rand_cycle(p_up, 0, 0, p_ft, 50);
            n++;
        end
        n_cmp++;
        if (m_state != st) begin
            n_err++;
            $display("FAIL wait_state: model state %0d, required %0d within %0d cycles", m_state, st, budget);
        end
    endtask

    // Per-cycle output monitor.
    initial begin
        logic [25:0] got, exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                got = {state, curr_row, score, lives, level, blink, sound_valid, sound_type};
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL outputs t=%0t got st=%0d row=%0d sc=%0d lv=%0d lvl=%0d bl=%0d v=%0d ty=%0d want st=%0d row=%0d sc=%0d lv=%0d lvl=%0d bl=%0d v=%0d ty=%0d",
                             $time, got[25:24], got[23:20], got[19:10], got[9:8], got[7:4], got[3], got[2], got[1:0],
                             exp[25:24], exp[23:20], exp[19:10], exp[9:8], exp[7:4], exp[3], exp[2], exp[1:0]);
                end
            end
        end
    end

    // Sound handshake monitor: each accepted request must match the oldest posted sound.
    initial begin
        logic [1:0] exp_t;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && sound_valid === 1'b1 && sound_ready === 1'b1) begin
                n_cmp++;
                if (snd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sound_accept t=%0t got type=%0d with no request expected", $time, sound_type);
                end else begin
                    exp_t = snd_q.pop_front();
                    if (sound_type !== exp_t) begin
                        n_err++;
                        $display("FAIL sound_accept t=%0t got type=%0d want %0d", $time, sound_type, exp_t);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; btn_up_tick = 1'b0; btn_down_tick = 1'b0;
        btn_any_tick = 1'b0; collision = 1'b0; sound_ready = 1'b0;
        model_step(0, 0, 0, 0, 0, 0, 0);

        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        // Idle in MENU: blink toggles every 30 frames.
        repeat (70) drive(1, 0, 0, 0, 0, 1, $urandom_range(1));

        // Start, then hold the sound request off for five cycles.
        drive(1, 0, 0, 1, 0, 0, 0);
        repeat (5) drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 1);

        // 3 up, 2 down, 2 up -> row 3, score 3; then simultaneous up/down.
        repeat (3) begin drive(1, 1, 0, 1, 0, 0, 1); drive(1, 0, 0, 0, 0, 0, 1); end
        repeat (2) begin drive(1, 0, 1, 1, 0, 0, 1); drive(1, 0, 0, 0, 0, 0, 1); end
        repeat (2) begin drive(1, 1, 0, 1, 0, 0, 1); drive(1, 0, 0, 0, 0, 0, 1); end
        drive(1, 1, 1, 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 1);

        // Climb to row 11, then up with collision in the same cycle.
        repeat (8) drive(1, 1, 0, 1, 0, 0, 1);
        drive(1, 1, 0, 1, 1, 0, 1);
        run_until(1, 0, 100, 200);
        drive(1, 0, 0, 0, 1, 1, 1);
        run_until(1, 0, 100, 200);
        drive(1, 0, 0, 0, 1, 0, 1);
        run_until(0, 0, 100, 200);
        repeat (65) drive(1, 0, 0, 0, 0, 1, 1);

        // Long collision-free run: repeated wins push the score to saturation.
        drive(1, 0, 0, 1, 0, 0, 1);
        repeat (7000) rand_cycle(50, 5, 0, 60, 50);
        run_until(3, 60, 60, 500);
        repeat (10) rand_cycle(0, 0, 0, 50, 50);
        repeat (2) drive(0, $urandom_range(1), 0, 1, 0, 1, 0);
        repeat (5) drive(1, 0, 0, 0, 0, 1, 1);

        // Free-running play including collisions and game overs.
        repeat (8000) rand_cycle(30, 10, 2, 50, 60);

        repeat (10) drive(1, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0 || snd_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d outputs and %0d sounds left, required 0 and 0", exp_q.size(), snd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
